igual_cero: RTL and testbench

- Registered zero detector. Flags when a WIDTH-bit input word ("tupla") equals zero.
- Also provides:
  - a valid strobe,
  - a rising-edge pulse when the detected condition becomes true,
  - a saturating count of zero samples.
- Used as a status/compare primitive in datapaths; 1-cycle latency from accepted sample to outputs.

---
 rtl/igual_cero_pkg.sv | 9 +
 rtl/cero_reduce.sv | 31 +++
 rtl/igual_cero.sv | 48 ++++
 tb/tb_igual_cero.sv | 124 ++++++++++++
 4 files changed

// File: rtl/igual_cero_pkg.sv
// Shared constants and word type for the igual_cero zero detector.
package igual_cero_pkg;

  localparam int unsigned IGUAL_CERO_WIDTH = 16;
  localparam int unsigned IGUAL_CERO_CNT_W = 16;

  typedef logic [IGUAL_CERO_WIDTH-1:0] tupla_t;

endpackage : igual_cero_pkg

// File: rtl/cero_reduce.sv
// Combinational zero test: balanced OR tree over the word, z = 1 iff all bits are 0.
module cero_reduce import igual_cero_pkg::*; #(
  parameter int unsigned WIDTH = IGUAL_CERO_WIDTH
) (
  input  logic [WIDTH-1:0] tupla,
  output logic             z
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned N      = 1 << LEVELS;

  // Heap-ordered tree: node i ORs children 2i+1 and 2i+2; leaves sit at N-1..2N-2.
  logic [2*N-2:0] node;

  genvar j;
  generate
    for (j = 0; j < N; j++) begin : g_leaf
      if (j < WIDTH) begin : g_bit
        assign node[N-1+j] = tupla[j];
      end else begin : g_pad
        assign node[N-1+j] = 1'b0;
      end
    end
    for (j = 0; j < N - 1; j++) begin : g_node
      assign node[j] = node[2*j+1] | node[2*j+2];
    end
  endgenerate

  assign z = ~node[0];

endmodule : cero_reduce

// File: rtl/igual_cero.sv
// Registered zero detector with valid strobe, rising-edge pulse and saturating zero count.
module igual_cero import igual_cero_pkg::*; #(
  parameter int unsigned WIDTH = IGUAL_CERO_WIDTH,
  parameter int unsigned CNT_W = IGUAL_CERO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] tupla,
  output logic             respuesta,
  output logic             respuesta_valid,
  output logic             cero_flanco,
  output logic [CNT_W-1:0] cero_cuenta
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic z;
  logic previo;

  cero_reduce #(.WIDTH(WIDTH)) u_reduce (
    .tupla (tupla),
    .z     (z)
  );

  // Result, strobe, edge and saturating counter; previo tracks the last accepted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      respuesta       <= 1'b0;
      respuesta_valid <= 1'b0;
      cero_flanco     <= 1'b0;
      cero_cuenta     <= '0;
      previo          <= 1'b0;
    end else if (en) begin
      respuesta       <= z;
      respuesta_valid <= 1'b1;
      cero_flanco     <= z & ~previo;
      previo          <= z;
      if (z && (cero_cuenta != CNT_MAX)) begin
        cero_cuenta <= cero_cuenta + CNT_W'(1);
      end
    end else begin
      respuesta_valid <= 1'b0;
      cero_flanco     <= 1'b0;
    end
  end

endmodule : igual_cero

// File: tb/tb_igual_cero.sv
// Scoreboard bench for igual_cero: directed vectors, default counter and a 2-bit saturating counter.
module tb_igual_cero;
  import igual_cero_pkg::*;

  typedef struct packed {
    logic        r;
    logic        v;
    logic        f;
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  tupla_t      tupla;
  logic        respuesta, respuesta_valid, cero_flanco;
  logic [15:0] cero_cuenta;
  logic        s_resp, s_valid, s_flanco;
  logic [1:0]  s_cuenta;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  igual_cero dut (
    .clk(clk), .rst(rst), .en(en), .tupla(tupla),
    .respuesta(respuesta), .respuesta_valid(respuesta_valid),
    .cero_flanco(cero_flanco), .cero_cuenta(cero_cuenta)
  );

  igual_cero #(.WIDTH(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .tupla(tupla),
    .respuesta(s_resp), .respuesta_valid(s_valid),
    .cero_flanco(s_flanco), .cero_cuenta(s_cuenta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the hand-computed response; c2 is the expected 2-bit count.
  task automatic apply(input logic r_i, input logic e_i, input logic [15:0] t_i,
                       input logic er, input logic ev, input logic ef,
                       input logic [15:0] ec, input logic [1:0] ec2);
    exp_t e;
    @(negedge clk);
    #1;
    rst   = r_i;
    en    = e_i;
    tupla = t_i;
    e.r = er; e.v = ev; e.f = ef; e.c = ec; e.c2 = ec2;
    q.push_back(e);
  endtask

  // Monitor: outputs seen at a falling edge answer the vector driven before the preceding rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (respuesta !== e.r) begin
          errors++;
          $display("FAIL respuesta vec %0d: got %b want %b", vectors, respuesta, e.r);
        end
        if (respuesta_valid !== e.v) begin
          errors++;
          $display("FAIL respuesta_valid vec %0d: got %b want %b", vectors, respuesta_valid, e.v);
        end
        if (cero_flanco !== e.f) begin
          errors++;
          $display("FAIL cero_flanco vec %0d: got %b want %b", vectors, cero_flanco, e.f);
        end
        if (cero_cuenta !== e.c) begin
          errors++;
          $display("FAIL cero_cuenta vec %0d: got %0d want %0d", vectors, cero_cuenta, e.c);
        end
        if (s_cuenta !== e.c2 || s_resp !== e.r || s_valid !== e.v || s_flanco !== e.f) begin
          errors++;
          $display("FAIL sat_instance vec %0d: got r%b v%b f%b c%0d want r%b v%b f%b c%0d",
                   vectors, s_resp, s_valid, s_flanco, s_cuenta, e.r, e.v, e.f, e.c2);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; tupla = '0;
    //     rst   en    tupla     r     v     f     cnt    cnt2
    apply(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd1, 2'd1);
    for (int i = 1; i <= 8; i++)
      apply(1'b0, 1'b1, 16'(i), 1'b0, 1'b1, 1'b0, 16'd1, 2'd1);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd2, 2'd2);
    apply(1'b0, 1'b1, 16'h0007, 1'b0, 1'b1, 1'b0, 16'd2, 2'd2);
    apply(1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 16'd2, 2'd2);
    apply(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16'd2, 2'd2);
    apply(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 16'd2, 2'd2);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd3, 2'd3);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd4, 2'd3);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd5, 2'd3);
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd5, 2'd3);
    apply(1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'd5, 2'd3);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd6, 2'd3);
    // Reset with a zero sample present: sample discarded, previous result cleared.
    apply(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'd1, 2'd1);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd2, 2'd2);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd3, 2'd3);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd4, 2'd3);
    apply(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd5, 2'd3);
    apply(1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 16'd5, 2'd3);
    apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd5, 2'd3);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_igual_cero
